// File: rtl/neurosync_nback.sv
// N-back reaction-game core: shows a pseudo-random one-hot stimulus per round and
// scores button presses against the stimulus shown n rounds earlier.
module neurosync_nback #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned T_SHOW = 1000,
    parameter int unsigned T_RESP = 3000,
    parameter logic [15:0] SEED   = 16'hACE1,
    localparam int unsigned NW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            jogar,
    input  logic [NW-1:0]   nivel,
    input  logic [N_CH-1:0] botoes,
    output logic [N_CH-1:0] leds,
    output logic            pronto,
    output logic            timeout,
    output logic [7:0]      acertos,
    output logic [7:0]      rodada,
    output logic [3:0]      db_estado
);

    localparam int unsigned IW   = $clog2(N_CH);
    localparam int unsigned TMAX = (T_SHOW > T_RESP) ? T_SHOW : T_RESP;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned HW   = $clog2(DEPTH + 1);

    localparam logic [2:0] INICIAL = 3'd0;
    localparam logic [2:0] PREPARA = 3'd1;
    localparam logic [2:0] MOSTRA  = 3'd2;
    localparam logic [2:0] ESPERA  = 3'd3;
    localparam logic [2:0] COMPARA = 3'd4;
    localparam logic [2:0] PROXIMA = 3'd5;
    localparam logic [2:0] FIM_OK  = 3'd6;
    localparam logic [2:0] FIM_TO  = 3'd7;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [15:0]     lfsr;
    logic [IW-1:0]   hist [0:DEPTH];
    logic [HW-1:0]   n_lat;
    logic [TW-1:0]   timer;
    logic [N_CH-1:0] botoes_prev;
    logic [N_CH-1:0] jog;

    logic [15:0]     lfsr_step_c;
    logic [IW-1:0]   idx_c;
    logic [IW-1:0]   target_c;
    logic            jogada_c;
    logic            correct_c;
    logic            warm_c;
    logic [31:0]     n_inc_c;
    logic [HW-1:0]   n_sel_c;
    logic            timed_c;

    // Fibonacci x^16+x^14+x^13+x^11, shifting left
    assign lfsr_step_c = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign idx_c       = IW'(lfsr[7:0] % 8'(N_CH));
    assign target_c    = hist[n_lat];
    assign jogada_c    = (state == ESPERA) && (botoes != '0) && (botoes_prev == '0);
    assign correct_c   = (jog == (N_CH'(1) << target_c));
    assign warm_c      = (rodada < 8'(n_lat));
    assign n_inc_c     = 32'(nivel) + 32'd1;
    assign n_sel_c     = (n_inc_c > 32'(DEPTH)) ? HW'(DEPTH) : HW'(n_inc_c);
    assign timed_c     = (state == MOSTRA) || (state == ESPERA);
    assign db_estado   = {1'b0, state};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INICIAL: if (jogar) state_next = PREPARA;
            PREPARA: state_next = MOSTRA;
            MOSTRA: begin
                if (timer == TW'(T_SHOW)) begin
                    state_next = warm_c ? PROXIMA : ESPERA;
                end
            end
            ESPERA: begin
                if (jogada_c) begin
                    state_next = COMPARA;
                end else if (timer == TW'(T_RESP - 1)) begin
                    state_next = FIM_TO;
                end
            end
            COMPARA: state_next = PROXIMA;
            PROXIMA: state_next = (rodada == 8'(ROUNDS - 1)) ? FIM_OK : MOSTRA;
            FIM_OK:  if (jogar) state_next = PREPARA;
            FIM_TO:  if (jogar) state_next = PREPARA;
            default: state_next = INICIAL;
        endcase
    end

    // Datapath: stimulus generation, history, scoring and round/timer bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr        <= SEED;
            for (int i = 0; i <= int'(DEPTH); i++) hist[i] <= '0;
            n_lat       <= HW'(1);
            timer       <= '0;
            botoes_prev <= '0;
            jog         <= '0;
            leds        <= '0;
            pronto      <= 1'b0;
            timeout     <= 1'b0;
            acertos     <= '0;
            rodada      <= '0;
        end else begin
            botoes_prev <= botoes;
            pronto      <= (state_next == FIM_OK);
            timeout     <= (state_next == FIM_TO);

            if ((state_next != state) || !timed_c) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if ((state == MOSTRA) && (timer < TW'(T_SHOW))) begin
                leds <= N_CH'(1) << idx_c;
            end else begin
                leds <= '0;
            end

            if (state == INICIAL && jogar) begin
                lfsr  <= SEED;
                n_lat <= n_sel_c;
            end else if ((state == FIM_OK || state == FIM_TO) && jogar) begin
                n_lat <= n_sel_c;
            end else if (state_next == MOSTRA && state != MOSTRA) begin
                lfsr <= lfsr_step_c;
            end

            if (state == PREPARA) begin
                rodada  <= '0;
                acertos <= '0;
                for (int i = 0; i <= int'(DEPTH); i++) hist[i] <= '0;
            end

            // entry 0 holds the stimulus just shown
            if (state == MOSTRA && state_next != MOSTRA) begin
                for (int i = int'(DEPTH); i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= idx_c;
            end

            if (jogada_c) begin
                jog <= botoes;
            end

            if (state == COMPARA && correct_c && acertos != 8'hFF) begin
                acertos <= acertos + 8'd1;
            end

            if (state == PROXIMA && state_next == MOSTRA) begin
                rodada <= rodada + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_neurosync_nback.sv
// Directed bench for neurosync_nback: reference LFSR/history model drives the
// player and predicts leds, score and end-of-game flags.
module tb_neurosync_nback;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ROUNDS = 8;
    localparam int unsigned T_SHOW = 4;
    localparam int unsigned T_RESP = 6;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic [1:0] nivel = 2'd0;
    logic [3:0] botoes = 4'd0;
    logic [3:0] leds;
    logic       pronto;
    logic       timeout;
    logic [7:0] acertos;
    logic [7:0] rodada;
    logic [3:0] db_estado;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_lfsr;
    int          mh [0:DEPTH];
    int          exp_ac;
    int          round_mode [ROUNDS];

    neurosync_nback #(
        .N_CH(N_CH), .DEPTH(DEPTH), .ROUNDS(ROUNDS),
        .T_SHOW(T_SHOW), .T_RESP(T_RESP), .SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .nivel(nivel),
        .botoes(botoes), .leds(leds), .pronto(pronto), .timeout(timeout),
        .acertos(acertos), .rodada(rodada), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic do_reset();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic set_modes(input int m);
        foreach (round_mode[i]) round_mode[i] = m;
    endtask

    // Plays one game from INICIAL; round_mode selects the response per round
    // (0 correct, 1 entry n-1, 2 two buttons, 3 wrong single, 4 held then re-pressed, 5 no press)
    task automatic play(input int nv, input int abort_r);
        int n, idx, tgt, lit, w;
        logic [3:0] good, p;
        n = nv + 1;
        m_lfsr = SEED;
        for (int i = 0; i <= int'(DEPTH); i++) mh[i] = 0;
        exp_ac = 0;
        nivel = 2'(nv);
        jogar = 1'b1;
        tick();
        check_val("prepara", 32'(db_estado), 32'd1);
        jogar = 1'b0;
        tick();
        check_val("mostra_entry", 32'(db_estado), 32'd2);
        check_val("leds_dark", 32'(leds), 32'd0);
        for (int r = 0; r < int'(ROUNDS); r++) begin
            m_lfsr = lfsr_next(m_lfsr);
            idx = int'(m_lfsr[7:0] % 8'(N_CH));
            for (int i = int'(DEPTH); i > 0; i--) mh[i] = mh[i-1];
            mh[0] = idx;
            tgt = mh[n];
            good = 4'd1 << tgt;
            w = 0;
            while (leds == 4'd0 && w < 20) begin
                tick();
                w++;
            end
            if (r == 0) check_val("first_leds_lat", 32'(w), 32'd1);
            check_val("leds", 32'(leds), 32'(4'd1 << idx));
            check_val("rodada", 32'(rodada), 32'(r));
            lit = 0;
            while (leds != 4'd0 && lit < 50) begin
                lit++;
                if (lit == 1 && r >= n && round_mode[r] == 4) botoes = good;
                tick();
            end
            check_val("show_len", 32'(lit), 32'(T_SHOW));
            if (r < n) begin
                check_val("warmup_proxima", 32'(db_estado), 32'd5);
                continue;
            end
            check_val("espera_entry", 32'(db_estado), 32'd3);
            if (r == abort_r) begin
                reset = 1'b0;
                #1;
                check_val("abort_state", 32'(db_estado), 32'd0);
                check_val("abort_leds", 32'(leds), 32'd0);
                check_val("abort_pronto", 32'(pronto), 32'd0);
                check_val("abort_timeout", 32'(timeout), 32'd0);
                check_val("abort_acertos", 32'(acertos), 32'd0);
                check_val("abort_rodada", 32'(rodada), 32'd0);
                return;
            end
            case (round_mode[r])
                1: p = 4'd1 << mh[n-1];
                2: p = 4'b0011;
                3: p = 4'd1 << ((tgt + 1) % int'(N_CH));
                4: begin
                    tick();
                    tick();
                    check_val("held_ignored", 32'(db_estado), 32'd3);
                    botoes = 4'd0;
                    tick();
                    check_val("released_wait", 32'(db_estado), 32'd3);
                    p = good;
                end
                5: begin
                    repeat (T_RESP - 1) tick();
                    check_val("to_last_wait", 32'(db_estado), 32'd3);
                    check_val("to_not_yet", 32'(timeout), 32'd0);
                    tick();
                    check_val("to_state", 32'(db_estado), 32'd7);
                    check_val("to_flag", 32'(timeout), 32'd1);
                    check_val("to_pronto", 32'(pronto), 32'd0);
                    check_val("to_acertos", 32'(acertos), 32'(exp_ac));
                    return;
                end
                default: p = good;
            endcase
            botoes = p;
            tick();
            check_val("compara", 32'(db_estado), 32'd4);
            botoes = 4'd0;
            if (p == good) exp_ac++;
            tick();
            check_val("proxima", 32'(db_estado), 32'd5);
            check_val("acertos", 32'(acertos), 32'(exp_ac));
        end
        w = 0;
        while (db_estado != 4'd6 && w < 10) begin
            tick();
            w++;
        end
        check_val("fim_ok", 32'(db_estado), 32'd6);
        check_val("pronto", 32'(pronto), 32'd1);
        check_val("no_timeout", 32'(timeout), 32'd0);
        check_val("final_acertos", 32'(acertos), 32'(exp_ac));
        check_val("final_rodada", 32'(rodada), 32'(ROUNDS - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with random inputs
        repeat (4) begin
            tick();
            jogar  = 1'($urandom_range(0, 1));
            nivel  = 2'($urandom_range(0, 3));
            botoes = 4'($urandom_range(0, 15));
        end
        #1;
        check_val("rst_state", 32'(db_estado), 32'd0);
        check_val("rst_leds", 32'(leds), 32'd0);
        check_val("rst_pronto", 32'(pronto), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_acertos", 32'(acertos), 32'd0);
        check_val("rst_rodada", 32'(rodada), 32'd0);
        tick();
        jogar = 1'b0;
        nivel = 2'd0;
        botoes = 4'd0;
        reset = 1'b1;
        repeat (5) tick();
        check_val("idle_state", 32'(db_estado), 32'd0);
        check_val("idle_leds", 32'(leds), 32'd0);

        // perfect play, n=1
        set_modes(0);
        play(0, -1);
        jogar = 1'b1;
        tick();
        check_val("restart_state", 32'(db_estado), 32'd1);
        check_val("restart_pronto", 32'(pronto), 32'd0);
        jogar = 1'b0;
        do_reset();

        // depth sweep, n=DEPTH, correct then off-by-one entry
        set_modes(0);
        play(3, -1);
        do_reset();
        set_modes(1);
        play(3, -1);
        do_reset();

        // response timeout in the first ESPERA, then restart clears it
        set_modes(5);
        play(0, -1);
        jogar = 1'b1;
        tick();
        check_val("to_restart_state", 32'(db_estado), 32'd1);
        check_val("to_restart_flag", 32'(timeout), 32'd0);
        jogar = 1'b0;
        do_reset();

        // multi-press, wrong press, held button
        set_modes(0);
        round_mode[1] = 2;
        round_mode[2] = 3;
        round_mode[3] = 4;
        play(0, -1);
        do_reset();

        // reset mid-ESPERA in round 5, then identical replay from SEED
        set_modes(0);
        play(0, 5);
        tick();
        reset = 1'b1;
        tick();
        play(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
